temp_avg_filter: RTL and testbench
==================================

TEMP_AVG_FILTER -- requirements
Module: temp_avg_filter

Interface
REQ-001 Parameter WIDTH, 10, sample and average width in bits.
REQ-002 Parameter LOG2_DEPTH, 2, log2 of averaging window; window N = 2^LOG2_DEPTH samples.
REQ-003 Parameter SPIKE_LIMIT, 10'd100, max accepted |sample - current average| when spike rejection is compiled in.
REQ-004 Parameter SPIKE_MAX_CONSEC, 3, consecutive rejections after which the next out-of-limit sample is force-accepted.
REQ-005 clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 adc_data  input  WIDTH  raw temperature sample.
REQ-008 adc_valid  input  1  adc_data is valid this cycle; no backpressure, every valid sample is consumed.
REQ-009 flush  input  1  discard window contents and refill.
REQ-010 avg_out  output  WIDTH  registered moving average; drives temp_in of the downstream temperature monitor.
REQ-011 avg_valid  output  1  one-cycle pulse, avg_out updated; drives temp_valid downstream.
REQ-012 filled  output  1  high while the state machine is in RUN.
REQ-013 spike_reject  output  1  one-cycle pulse, sample discarded as spike.

Function
REQ-014 The block SHALL implement a two-state FSM: FILL (window not full) and RUN (window full).
REQ-015 The block SHALL store samples in an N-entry circular buffer with a LOG2_DEPTH-bit write pointer that wraps from N-1 to 0.
REQ-016 The block SHALL keep a running sum of WIDTH+LOG2_DEPTH bits, which SHALL never overflow.
REQ-017 In FILL, each accepted sample SHALL be written, added to the sum and increment a fill counter, with no avg_valid.
REQ-018 On the accepted sample that makes the fill count reach N, the FSM SHALL move to RUN and avg_valid SHALL pulse the next cycle.
REQ-019 In RUN, each accepted sample SHALL overwrite the oldest entry, and sum SHALL become sum - oldest + new in the same cycle.
REQ-020 avg_out SHALL equal the updated sum shifted right by LOG2_DEPTH (truncated), registered with avg_valid: latency exactly 1 cycle after adc_valid.
REQ-021 avg_out SHALL hold its value between avg_valid pulses.
REQ-022 flush SHALL clear sum, pointer, fill counter and buffer, and SHALL force FILL next cycle; avg_out SHALL hold.
REQ-023 If flush and adc_valid are asserted in the same cycle, flush SHALL win, the sample SHALL be dropped and no avg_valid SHALL occur.
REQ-024 Back-to-back adc_valid on every cycle SHALL be supported with one avg_valid per accepted RUN sample.

Reset
REQ-025 On rst, avg_out=0, avg_valid=0, filled=0, spike_reject=0, sum=0, pointer=0, fill count=0, consecutive-reject count=0, buffer=0, and state=FILL.
REQ-026 rst SHALL take priority over flush and adc_valid, and rst asserted mid-fill or mid-run SHALL discard all window contents.

Configuration
REQ-027 Macro TEMP_SPIKE_REJECT_EN SHALL control spike rejection.
REQ-028 With TEMP_SPIKE_REJECT_EN defined, a RUN-state sample with |adc_data - avg_out| > SPIKE_LIMIT SHALL be discarded with no buffer or sum change and no avg_valid.
REQ-029 With TEMP_SPIKE_REJECT_EN defined, a discarded sample SHALL pulse spike_reject the next cycle and increment the consecutive-reject count.
REQ-030 With TEMP_SPIKE_REJECT_EN defined, when the consecutive-reject count equals SPIKE_MAX_CONSEC, the next out-of-limit sample SHALL be accepted, and any accepted sample SHALL clear the count.
REQ-031 With TEMP_SPIKE_REJECT_EN defined, no rejection SHALL occur in FILL.
REQ-032 Without TEMP_SPIKE_REJECT_EN, every sample SHALL be accepted, spike_reject SHALL be tied 0 and no comparison logic SHALL be synthesized.

Verification
REQ-033 Scenario: after rst, samples 100,200,300,400 -> no avg_valid on the first three; avg_valid with avg_out=250 one cycle after 400; filled=1.
REQ-034 Scenario: continue with sample 500 -> avg_out=350 (sum 1400).
REQ-035 Scenario: the next six samples 500 -> avg_out converges to 500, and pointer wrap causes no glitch.
REQ-036 Scenario: in RUN, flush plus adc_valid=700 in the same cycle -> no avg_valid, filled=0, and avg_out=500 holds; the next four samples of 40 -> avg_out=40.
REQ-037 Scenario: window 1,1,1,2 -> avg_out=1 (truncation); rst after two samples, then 8,8,8,8 -> avg_out=8.
REQ-038 Scenario (TEMP_SPIKE_REJECT_EN): window of 400s, samples 900,900,900 -> three spike_reject pulses, avg_out stays 400; fourth 900 accepted -> avg_out=525.

Source files
------------

// File: rtl/temp_avg_filter.sv
// temp_avg_filter: moving-average filter for raw ADC temperature samples.
// Keeps an N = 2**LOG2_DEPTH entry circular window and a running sum.
// After N samples have been taken (FILL -> RUN), each accepted sample
// produces a registered average one cycle later.
// Optional build macro: TEMP_SPIKE_REJECT_EN (spike rejection in RUN).
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   adc_data     raw sample, WIDTH bits
//   adc_valid    adc_data valid this cycle (always consumed)
//   flush        discard window contents and refill
//   avg_out      registered moving average (held between updates)
//   avg_valid    one-cycle pulse when avg_out updates
//   filled       high while the window is full (RUN)
//   spike_reject one-cycle pulse when a sample was discarded as a spike
module temp_avg_filter #(
   parameter int               WIDTH            = 10,
   parameter int               LOG2_DEPTH       = 2,
   parameter logic [WIDTH-1:0] SPIKE_LIMIT      = WIDTH'(100),
   parameter int               SPIKE_MAX_CONSEC = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] adc_data,
   input  logic             adc_valid,
   input  logic             flush,
   output logic [WIDTH-1:0] avg_out,
   output logic             avg_valid,
   output logic             filled,
   output logic             spike_reject
);

   localparam int N  = 1 << LOG2_DEPTH;
   localparam int SW = WIDTH + LOG2_DEPTH;

   typedef enum logic {S_FILL, S_RUN} state_t;

   state_t r_state;
   state_t w_next;

   logic [WIDTH-1:0]      r_buf [N];
   logic [LOG2_DEPTH-1:0] r_wptr;
   logic [LOG2_DEPTH:0]   r_fill_cnt;
   logic [SW-1:0]         r_sum;
   logic [WIDTH-1:0]      r_avg;
   logic                  r_avg_valid;

   logic [WIDTH-1:0]      w_old;
   logic [SW-1:0]         w_sum_next;
   logic                  w_fill_last;
   logic                  w_reject;
   logic                  w_accept;
   logic                  w_emit;

   // In FILL nothing is evicted; in RUN the slot under the write
   // pointer is the oldest sample and leaves the sum.
   assign w_old = (r_state == S_RUN) ? r_buf[r_wptr] : '0;

   // sum - oldest never underflows, and adding one WIDTH-bit sample
   // to N-1 others always fits in WIDTH+LOG2_DEPTH bits.
   assign w_sum_next = r_sum - {{LOG2_DEPTH{1'b0}}, w_old}
                             + {{LOG2_DEPTH{1'b0}}, adc_data};

   assign w_fill_last = (r_fill_cnt == (LOG2_DEPTH+1)'(N - 1));
   assign w_accept    = adc_valid & ~flush & ~w_reject;
   assign w_emit      = w_accept & ((r_state == S_RUN) | w_fill_last);

`ifdef TEMP_SPIKE_REJECT_EN
   localparam int CW = (SPIKE_MAX_CONSEC > 0) ?
                       $clog2(SPIKE_MAX_CONSEC + 1) : 1;

   logic [CW-1:0]    r_rej_cnt;
   logic             r_spike;
   logic [WIDTH-1:0] w_diff;
   logic             w_over;

   assign w_diff = (adc_data >= r_avg) ? (adc_data - r_avg)
                                       : (r_avg - adc_data);
   assign w_over = (w_diff > SPIKE_LIMIT);

   // Once SPIKE_MAX_CONSEC spikes in a row were dropped, the next
   // out-of-limit sample is taken as a genuine step change.
   assign w_reject = adc_valid & ~flush & (r_state == S_RUN) & w_over
                   & (r_rej_cnt != CW'(SPIKE_MAX_CONSEC));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rej_cnt <= '0;
         r_spike   <= 1'b0;
      end else begin
         r_spike <= w_reject;
         if (flush)
            r_rej_cnt <= '0;
         else if (w_reject)
            r_rej_cnt <= r_rej_cnt + 1'b1;
         else if (w_accept)
            r_rej_cnt <= '0;
      end
   end

   assign spike_reject = r_spike;
`else
   assign w_reject     = 1'b0;
   assign spike_reject = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_FILL;
      else
         r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      if (flush) begin
         w_next = S_FILL;
      end else begin
         unique case (r_state)
            S_FILL:  if (w_accept && w_fill_last) w_next = S_RUN;
            S_RUN:   w_next = S_RUN;
            default: w_next = S_FILL;
         endcase
      end
   end

   // Output logic
   always_comb begin
      filled = (r_state == S_RUN);
   end

   // Window, running sum and registered average
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) r_buf[i] <= '0;
         r_wptr      <= '0;
         r_fill_cnt  <= '0;
         r_sum       <= '0;
         r_avg       <= '0;
         r_avg_valid <= 1'b0;
      end else if (flush) begin
         for (int i = 0; i < N; i++) r_buf[i] <= '0;
         r_wptr      <= '0;
         r_fill_cnt  <= '0;
         r_sum       <= '0;
         r_avg_valid <= 1'b0;
      end else begin
         r_avg_valid <= w_emit;
         if (w_accept) begin
            r_buf[r_wptr] <= adc_data;
            r_wptr        <= r_wptr + 1'b1;
            r_sum         <= w_sum_next;
            if (r_state == S_FILL)
               r_fill_cnt <= r_fill_cnt + 1'b1;
         end
         if (w_emit)
            r_avg <= w_sum_next[SW-1:LOG2_DEPTH];
      end
   end

   assign avg_out   = r_avg;
   assign avg_valid = r_avg_valid;

endmodule

// File: tb/tb_temp_avg_filter.sv
// tb_temp_avg_filter: directed vectors for temp_avg_filter.
// Spike-rejection vectors are used when TEMP_SPIKE_REJECT_EN is defined.
module tb_temp_avg_filter;

   logic       clk;
   logic       rst;
   logic [9:0] adc_data;
   logic       adc_valid;
   logic       flush;
   logic [9:0] avg_out;
   logic       avg_valid;
   logic       filled;
   logic       spike_reject;

   int n_tot;
   int n_bad;

   temp_avg_filter dut (
      .clk          (clk),
      .rst          (rst),
      .adc_data     (adc_data),
      .adc_valid    (adc_valid),
      .flush        (flush),
      .avg_out      (avg_out),
      .avg_valid    (avg_valid),
      .filled       (filled),
      .spike_reject (spike_reject)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Apply inputs for one clock; outputs are sampled 1 time unit
   // after the edge, so they reflect this cycle's inputs.
   task automatic step(input logic v, input int d, input logic f);
      adc_valid = v;
      adc_data  = 10'(d);
      flush     = f;
      @(posedge clk);
      #1;
      adc_valid = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b1, 77, 1'b1);
      step(1'b0, 0, 1'b0);
      rst = 1'b0;
   endtask

   int exp_conv [6] = '{425, 475, 500, 500, 500, 500};

   initial begin
      n_tot     = 0;
      n_bad     = 0;
      rst       = 1'b1;
      adc_data  = '0;
      adc_valid = 1'b0;
      flush     = 1'b0;
      do_reset();

      check("rst_avg",    int'(avg_out),      0);
      check("rst_valid",  int'(avg_valid),    0);
      check("rst_filled", int'(filled),       0);
      check("rst_spike",  int'(spike_reject), 0);

      // Fill: 100,200,300,400 -> 250 on the fourth
      step(1'b1, 100, 1'b0);
      check("fill1_valid", int'(avg_valid), 0);
      step(1'b1, 200, 1'b0);
      check("fill2_valid", int'(avg_valid), 0);
      step(1'b1, 300, 1'b0);
      check("fill3_valid",  int'(avg_valid), 0);
      check("fill3_filled", int'(filled),    0);
      step(1'b1, 400, 1'b0);
      check("fill4_valid",  int'(avg_valid), 1);
      check("fill4_avg",    int'(avg_out),   250);
      check("fill4_filled", int'(filled),    1);
      step(1'b0, 0, 1'b0);
      check("idle_valid", int'(avg_valid), 0);
      check("idle_hold",  int'(avg_out),   250);

      // 500 -> sum 1400 -> 350
      step(1'b1, 500, 1'b0);
      check("run500_valid", int'(avg_valid), 1);
      check("run500_avg",   int'(avg_out),   350);

      // Six back-to-back 500s, pointer wraps mid-way
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 500, 1'b0);
         check($sformatf("conv%0d_valid", i), int'(avg_valid), 1);
         check($sformatf("conv%0d_avg", i),   int'(avg_out),   exp_conv[i]);
      end

      // Flush with a sample in the same cycle: sample dropped
      step(1'b1, 700, 1'b1);
      check("flush_valid",  int'(avg_valid), 0);
      check("flush_filled", int'(filled),    0);
      check("flush_hold",   int'(avg_out),   500);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 40, 1'b0);
         check($sformatf("refill%0d_valid", i), int'(avg_valid), 0);
         check($sformatf("refill%0d_hold", i),  int'(avg_out),   500);
      end
      step(1'b1, 40, 1'b0);
      check("refill3_valid",  int'(avg_valid), 1);
      check("refill3_avg",    int'(avg_out),   40);
      check("refill3_filled", int'(filled),    1);

      // Truncation: 1,1,1,2 -> 5/4 = 1
      do_reset();
      step(1'b1, 1, 1'b0);
      step(1'b1, 1, 1'b0);
      step(1'b1, 1, 1'b0);
      step(1'b1, 2, 1'b0);
      check("trunc_valid", int'(avg_valid), 1);
      check("trunc_avg",   int'(avg_out),   1);

      // Reset mid-fill discards the two samples taken
      do_reset();
      step(1'b1, 8, 1'b0);
      step(1'b1, 8, 1'b0);
      do_reset();
      check("midrst_avg",    int'(avg_out), 0);
      check("midrst_filled", int'(filled),  0);
      step(1'b1, 8, 1'b0);
      step(1'b1, 8, 1'b0);
      step(1'b1, 8, 1'b0);
      check("midrst3_valid", int'(avg_valid), 0);
      step(1'b1, 8, 1'b0);
      check("midrst4_valid", int'(avg_valid), 1);
      check("midrst4_avg",   int'(avg_out),   8);

`ifdef TEMP_SPIKE_REJECT_EN
      // Window of 400s; three 900s rejected, fourth forced in
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 400, 1'b0);
      check("spk_base_avg", int'(avg_out), 400);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 900, 1'b0);
         check($sformatf("spk%0d_pulse", i), int'(spike_reject), 1);
         check($sformatf("spk%0d_valid", i), int'(avg_valid),    0);
         check($sformatf("spk%0d_avg", i),   int'(avg_out),      400);
      end
      step(1'b1, 900, 1'b0);
      check("spk_force_pulse", int'(spike_reject), 0);
      check("spk_force_valid", int'(avg_valid),    1);
      check("spk_force_avg",   int'(avg_out),      525);
      step(1'b0, 0, 1'b0);
      check("spk_idle_pulse", int'(spike_reject), 0);
`else
      // No rejection: 900 against a window of 8s is accepted
      step(1'b1, 900, 1'b0);
      check("nospk_pulse", int'(spike_reject), 0);
      check("nospk_valid", int'(avg_valid),    1);
      check("nospk_avg",   int'(avg_out),      231);
`endif

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
